// File: rtl/d_ff.sv
// Positive-edge D register with synchronous, active-high clear to a
// parameterizable value. Q comes straight from the register.
module d_ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // A ternary rather than if/else, so an unknown CLR merges both choices and
  // gives X on Q in simulation instead of silently selecting D.
  always_ff @(posedge CLK) begin
    Q <= CLR ? CLR_VALUE : D;
  end

endmodule

// File: tb/tb_d_ff.sv
// Self-checking bench for d_ff: a default 1-bit instance and an 8-bit
// instance with a non-zero clear value, both driven on falling edges.
module tb_d_ff;

  localparam logic [7:0] CLR8 = 8'hA5;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       d   = 1'b0;
  logic       q;
  logic       clr8 = 1'b1;
  logic [7:0] d8   = 8'h00;
  logic [7:0] q8;

  int checks = 0;
  int errors = 0;

  // Expected Q values in edge order, filled from the clear/capture rule.
  logic [7:0] exp_q[$];

  typedef struct {
    logic clr;
    logic d;
    logic q;
  } vec_t;

  vec_t vecs[13];

  d_ff dut (
    .CLK (clk),
    .CLR (clr),
    .D   (d),
    .Q   (q)
  );

  d_ff #(.WIDTH(8), .CLR_VALUE(CLR8)) dut8 (
    .CLK (clk),
    .CLR (clr8),
    .D   (d8),
    .Q   (q8)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Drive the narrow instance on a falling edge, then check just after the rise.
  task automatic step(input logic c, input logic dv, input logic req, input string name);
    @(negedge clk);
    clr = c;
    d   = dv;
    @(posedge clk);
    #1;
    check(name, {7'b0, q}, {7'b0, req});
  endtask

  task automatic step8(input logic c, input logic [7:0] dv, input logic [7:0] req, input string name);
    @(negedge clk);
    clr8 = c;
    d8   = dv;
    @(posedge clk);
    #1;
    check(name, q8, req);
  endtask

  initial begin
    logic       rc;
    logic       rd;
    logic [7:0] r8;

    vecs[0]  = '{1'b1, 1'b1, 1'b0};  // initial clear beats D=1
    vecs[1]  = '{1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1'b1};  // capture 1,0,0,1
    vecs[3]  = '{1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0};  // clear priority for 3 edges
    vecs[7]  = '{1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1};  // release loads D
    vecs[10] = '{1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1};

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].clr, vecs[i].d, vecs[i].q, $sformatf("vec%0d", i));
    end

    // Synchronous clear: Q must not move until the rising edge.
    @(negedge clk);
    clr = 1'b1;
    #2;
    check("clr_before_edge", {7'b0, q}, 8'h01);
    @(posedge clk);
    #1;
    check("clr_at_edge", {7'b0, q}, 8'h00);
    step(1'b0, 1'b1, 1'b1, "clr_release");

    // D glitch 1->0->1 between edges leaves the captured value at 1.
    @(negedge clk);
    d = 1'b0;
    #1;
    check("glitch_hold_mid", {7'b0, q}, 8'h01);
    d = 1'b1;
    @(posedge clk);
    #1;
    check("glitch_d", {7'b0, q}, 8'h01);

    // CLR pulse that ends before the edge has no effect.
    @(negedge clk);
    clr = 1'b1;
    d   = 1'b0;
    #2;
    clr = 1'b0;
    #1;
    check("clr_glitch_mid", {7'b0, q}, 8'h01);
    @(posedge clk);
    #1;
    check("clr_glitch_edge", {7'b0, q}, 8'h00);

    // Randomized: 200 edges, a one-cycle clear with 50% chance every 3 cycles.
    for (int n = 0; n < 200; n++) begin
      rc = (n % 3 == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      rd = 1'($urandom_range(0, 1));
      @(negedge clk);
      clr = rc;
      d   = rd;
      exp_q.push_back(rc ? 8'h00 : {7'b0, rd});
      @(posedge clk);
      #1;
      check($sformatf("rand%0d", n), {7'b0, q}, exp_q.pop_front());
    end

    // 8-bit instance with CLR_VALUE = 8'hA5.
    step8(1'b1, 8'h3C, CLR8, "w8_clr_first");
    step8(1'b0, 8'h3C, 8'h3C, "w8_capture");
    step8(1'b1, 8'hFF, CLR8, "w8_clr");
    step8(1'b1, 8'h00, CLR8, "w8_clr_hold");
    for (int n = 0; n < 20; n++) begin
      rc = 1'($urandom_range(0, 3) == 0);
      r8 = 8'($urandom_range(0, 255));
      exp_q.push_back(rc ? CLR8 : r8);
      step8(rc, r8, exp_q.pop_front(), $sformatf("w8_rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
